// File: rtl/mantissa_sqrt_seq.sv
// Sequential restoring square root of a normalized 24-bit mantissa.
// Latency: ready pulses 24 edges after the start edge (12 with SQRT_TWO_BITS_PER_CYCLE_EN).
// Backpressure: none; start is ignored while busy, and is accepted in IDLE or DONE.
//
// Ports:
//   clk     - clock, rising edge
//   clrn    - asynchronous active-low reset
//   start   - request strobe, sampled on the rising edge
//   d       - 24-bit mantissa; the radicand is {d, 24'b0}
//   sa      - even shift amount, carried through to sa_out
//   busy    - high while root bits are being retired
//   ready   - one-cycle pulse when q / rem_nz / sa_out are valid
//   q       - floor(sqrt({d, 24'b0}))
//   rem_nz  - final partial remainder is non-zero (inexact root)
//   sa_out  - sa captured with the accepted request
//
// Build option: define SQRT_TWO_BITS_PER_CYCLE_EN to retire two root bits
// per edge through two cascaded restoring steps. Results are identical.

module mantissa_sqrt_seq (
  input  logic        clk,
  input  logic        clrn,
  input  logic        start,
  input  logic [23:0] d,
  input  logic [4:0]  sa,
  output logic        busy,
  output logic        ready,
  output logic [23:0] q,
  output logic        rem_nz,
  output logic [4:0]  sa_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [23:0] rad;   // radicand bits still to be consumed, MSB pair first
  logic [25:0] rem;   // partial remainder
  logic [4:0]  cnt;   // remaining iterations minus one

  // One restoring step. Returns {new_rem[25:0], new_q[23:0]}.
  // The trial value {q,01} is compared against {rem,pair} at full width so
  // the sign is exact; the kept difference always fits in 26 bits because
  // the remainder never exceeds 2*q.
  function automatic logic [49:0] sqrt_step(input logic [25:0] r,
                                            input logic [23:0] qq,
                                            input logic [1:0]  pair);
    logic        ge;
    logic [25:0] diff;
    ge   = ({r, pair} >= {2'b00, qq, 2'b01});
    diff = {r[23:0], pair} - {qq, 2'b01};
    if (ge)
      sqrt_step = {diff, qq[22:0], 1'b1};
    else
      sqrt_step = {r[23:0], pair, qq[22:0], 1'b0};
  endfunction

  logic [49:0] step1;
  logic [25:0] nxt_rem;
  logic [23:0] nxt_q;
  logic [23:0] nxt_rad;

  assign step1 = sqrt_step(rem, q, rad[23:22]);

`ifdef SQRT_TWO_BITS_PER_CYCLE_EN
  localparam logic [4:0] CNT_INIT = 5'd11;
  logic [49:0] step2;
  assign step2   = sqrt_step(step1[49:24], step1[23:0], rad[21:20]);
  assign nxt_rem = step2[49:24];
  assign nxt_q   = step2[23:0];
  assign nxt_rad = {rad[19:0], 4'b0000};
`else
  localparam logic [4:0] CNT_INIT = 5'd23;
  assign nxt_rem = step1[49:24];
  assign nxt_q   = step1[23:0];
  assign nxt_rad = {rad[21:0], 2'b00};
`endif

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state  <= IDLE;
      rad    <= 24'h000000;
      rem    <= 26'h0000000;
      cnt    <= 5'd0;
      q      <= 24'h000000;
      sa_out <= 5'h00;
      rem_nz <= 1'b0;
      busy   <= 1'b0;
      ready  <= 1'b0;
    end else begin
      case (state)
        // DONE behaves like IDLE for acceptance, so back-to-back requests
        // see no idle bubble.
        IDLE, DONE: begin
          ready <= 1'b0;
          busy  <= 1'b0;
          if (start) begin
            rad    <= d;
            rem    <= 26'h0000000;
            q      <= 24'h000000;
            rem_nz <= 1'b0;
            sa_out <= sa;
            cnt    <= CNT_INIT;
            busy   <= 1'b1;
            state  <= CALC;
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          rem <= nxt_rem;
          q   <= nxt_q;
          rad <= nxt_rad;
          cnt <= cnt - 5'd1;
          if (cnt == 5'd0) begin
            busy   <= 1'b0;
            ready  <= 1'b1;
            rem_nz <= |nxt_rem;
            state  <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          ready <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mantissa_sqrt_seq.sv
// Self-checking bench for mantissa_sqrt_seq: directed table, corner sequences,
// and random mantissas checked against an arithmetic floor-sqrt model.
module tb_mantissa_sqrt_seq;

  logic        clk = 1'b0;
  logic        clrn;
  logic        start;
  logic [23:0] d;
  logic [4:0]  sa;
  logic        busy;
  logic        ready;
  logic [23:0] q;
  logic        rem_nz;
  logic [4:0]  sa_out;

`ifdef SQRT_TWO_BITS_PER_CYCLE_EN
  localparam int LAT = 12;
`else
  localparam int LAT = 24;
`endif

  mantissa_sqrt_seq dut (
    .clk    (clk),
    .clrn   (clrn),
    .start  (start),
    .d      (d),
    .sa     (sa),
    .busy   (busy),
    .ready  (ready),
    .q      (q),
    .rem_nz (rem_nz),
    .sa_out (sa_out)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [23:0] d;
    logic [4:0]  sa;
    logic [23:0] q;
    logic        nz;
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // floor(sqrt(d * 2^24)) by plain arithmetic, with exactness flag.
  task automatic model(input logic [23:0] dd, output logic [23:0] eq, output logic enz);
    longint rr;
    longint r;
    rr = longint'(dd) << 24;
    r  = longint'($sqrt(real'(rr)));
    while (r * r > rr) r--;
    while ((r + 1) * (r + 1) <= rr) r++;
    eq  = r[23:0];
    enz = (rr != r * r);
  endtask

  // Drive a start pulse; returns at the negedge just after the start edge.
  task automatic launch(input logic [23:0] dd, input logic [4:0] ss);
    @(negedge clk);
    d = dd; sa = ss; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count edges since the start edge until ready is seen (bounded).
  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_check(input string name, input logic [23:0] dd, input logic [4:0] ss,
                           input logic [23:0] eq, input logic enz);
    int n;
    logic [23:0] qheld;
    launch(dd, ss);
    chk({name, " busy"}, busy, 1);
    wait_ready(n);
    chk({name, " latency"}, n, LAT);
    chk({name, " q"}, q, eq);
    chk({name, " rem_nz"}, rem_nz, enz);
    chk({name, " sa_out"}, sa_out, ss);
    qheld = q;
    @(negedge clk);
    chk({name, " ready pulse"}, ready, 0);
    chk({name, " q hold"}, q, qheld);
  endtask

  vec_t vecs[8];

  initial begin
    int n;
    int pulses;
    logic [23:0] eq;
    logic enz;
    logic [23:0] rd;

    vecs[0] = '{24'h400000, 5'd2,  24'h800000, 1'b0};
    vecs[1] = '{24'h800000, 5'd4,  24'hB504F3, 1'b1};
    vecs[2] = '{24'hFFFFFF, 5'd6,  24'hFFFFFF, 1'b1};
    vecs[3] = '{24'h900000, 5'd8,  24'hC00000, 1'b0};
    vecs[4] = '{24'h000000, 5'd30, 24'h000000, 1'b0};
    vecs[5] = '{24'h000001, 5'd10, 24'h001000, 1'b0};
    vecs[6] = '{24'h000003, 5'd12, 24'h001BB6, 1'b1};
    vecs[7] = '{24'h200000, 5'd14, 24'h5A8279, 1'b1};

    // Reset state, with start asserted to show it has no effect in reset.
    clrn = 1'b0; start = 1'b1; d = 24'h123456; sa = 5'd7;
    repeat (3) @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset ready", ready, 0);
    chk("reset q", q, 0);
    chk("reset rem_nz", rem_nz, 0);
    chk("reset sa_out", sa_out, 0);
    start = 1'b0;
    clrn  = 1'b1;

    // Start immediately after reset release is accepted on the first edge.
    for (int i = 0; i < 8; i++)
      run_check($sformatf("vec%0d", i), vecs[i].d, vecs[i].sa, vecs[i].q, vecs[i].nz);

    // Busy ignore: second start at edge 5 must not disturb the first request.
    @(negedge clk);
    d = 24'h900000; sa = 5'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    repeat (4) begin @(negedge clk); n++; end
    d = 24'h400000; sa = 5'd9; start = 1'b1;
    @(negedge clk); n++;
    start = 1'b0;
    while (!ready && n < 200) begin @(negedge clk); n++; end
    chk("ignore latency", n, LAT);
    chk("ignore q", q, 24'hC00000);
    chk("ignore sa_out", sa_out, 5'd3);
    pulses = 0;
    repeat (40) begin @(negedge clk); if (ready) pulses++; end
    chk("ignore no second ready", pulses, 0);

    // Back-to-back: start held in the DONE cycle.
    launch(24'hFFFFFF, 5'd1);
    wait_ready(n);
    chk("b2b first q", q, 24'hFFFFFF);
    d = 24'h900000; sa = 5'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b no bubble busy", busy, 1);
    wait_ready(n);
    chk("b2b latency", n, LAT);
    chk("b2b q", q, 24'hC00000);
    chk("b2b rem_nz", rem_nz, 0);
    chk("b2b sa_out", sa_out, 5'd5);

    // Reset abort at edge 10.
    launch(24'hFFFFFF, 5'd17);
    repeat (9) @(negedge clk);
    @(posedge clk);
    #1 clrn = 1'b0;
    #1;
    chk("abort busy", busy, 0);
    chk("abort ready", ready, 0);
    chk("abort q", q, 0);
    chk("abort rem_nz", rem_nz, 0);
    chk("abort sa_out", sa_out, 0);
    repeat (3) @(negedge clk);
    clrn = 1'b1;
    pulses = 0;
    repeat (40) begin @(negedge clk); if (ready) pulses++; end
    chk("abort no ready", pulses, 0);
    run_check("after abort", 24'h800000, 5'd11, 24'hB504F3, 1'b1);

    // Random mantissas, a quarter of them unnormalized.
    for (int i = 0; i < 40; i++) begin
      rd = 24'($urandom);
      if ($urandom_range(0, 3) == 0) rd = rd >> $urandom_range(2, 23);
      model(rd, eq, enz);
      run_check($sformatf("rand%0d d=%06h", i, rd), rd, 5'($urandom_range(0, 31)), eq, enz);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mantissa_sqrt_seq.md
MANTISSA_SQRT_SEQ -- requirements
Module: mantissa_sqrt_seq

Interface
REQ-001 The block SHALL have these ports, one per line (name  direction  width  meaning), clock and reset first.
- clk  in  1  single clock; all state updates on the rising edge.
- clrn  in  1  reset; asynchronous, active-low.
- start  in  1  request; sampled on the rising edge.
- d  in  24  normalized mantissa from the even-shift normalizer; d[23:22] is 1x or 01.
- sa  in  5  even shift amount paired with d; passed through.
- busy  out  1  iteration in progress.
- ready  out  1  one-cycle pulse; q, rem_nz and sa_out are valid.
- q  out  24  floor(sqrt({d,24'b0})).
- rem_nz  out  1  sticky; final partial remainder is non-zero.
- sa_out  out  5  sa captured with the accepted request.

REQ-002 There SHALL be no parameters; all widths are fixed as listed.

Function
REQ-003 The radicand SHALL be R = {d,24'b0} (48 bits); q SHALL be floor(sqrt(R)), exact for every 24-bit d.
REQ-004 The algorithm SHALL be restoring digit-by-digit square root.
- Partial remainder: 26 bits.
- Per root bit: trial subtract {rem,2 radicand bits} - {q,2'b01}.
- Keep the difference and shift in 1 when it is non-negative, else restore and shift in 0.
REQ-005 The state machine SHALL have three states: IDLE, CALC, DONE.
REQ-006 In IDLE, start=1 at a rising edge SHALL:
- load d into the radicand shift register;
- clear q and the remainder;
- capture sa into sa_out;
- load the iteration counter;
- enter CALC.
REQ-007 In CALC, each rising edge SHALL retire one root bit, MSB first, and decrement the counter; after the last bit the state SHALL go to DONE.
REQ-008 ready SHALL be 1 only in DONE, for exactly one cycle.
- It rises on the 24th rising edge after the edge that sampled start.
- In DONE, rem_nz SHALL equal OR of the final remainder bits.
REQ-009 busy SHALL be 1 exactly while the state is CALC.
REQ-010 start while in CALC SHALL be ignored: no effect on state, q, remainder or sa_out.
REQ-011 start=1 in DONE SHALL be accepted as in IDLE, giving back-to-back operation with no idle bubble; otherwise DONE SHALL return to IDLE.
REQ-012 q, rem_nz and sa_out SHALL hold their values after DONE until the next accepted start.
REQ-013 An unnormalized d (d[23:22]=00, including d=0) SHALL still yield floor(sqrt(R)); no error flag is raised.

Reset
REQ-014 While clrn=0, the block SHALL be in IDLE with these outputs:
- busy=0, ready=0, rem_nz=0;
- q=24'h000000, sa_out=5'h00;
- internal remainder and counter cleared.
REQ-015 clrn asserted mid-operation SHALL abort immediately and asynchronously. No ready pulse for the aborted request SHALL ever appear.
REQ-016 After clrn deasserts, the first start SHALL be accepted on the first rising edge at which it is sampled high.

Configuration
REQ-017 When the macro SQRT_TWO_BITS_PER_CYCLE_EN is defined:
- CALC SHALL retire two root bits per rising edge (two cascaded restoring steps);
- ready SHALL rise on the 12th rising edge after the start edge;
- results SHALL be bit-identical to the default build.
REQ-018 When SQRT_TWO_BITS_PER_CYCLE_EN is undefined, the block SHALL retire one bit per edge, with 24-edge latency.

Verification
REQ-019 The bench SHALL cover these directed scenarios (stimulus -> required response):
- d=24'h400000, sa=5'd2 -> q=24'h800000, rem_nz=0, sa_out=5'd2; ready rises at edge 24 (edge 12 with the macro).
- d=24'h800000 -> q=24'hB504F3, rem_nz=1.
- d=24'hFFFFFF -> q=24'hFFFFFF, rem_nz=1; then d=24'h900000 -> q=24'hC00000, rem_nz=0.
- Busy ignore: start with d=24'h900000; pulse start with d=24'h400000 at edge 5 -> single result q=24'hC00000.
- Back-to-back: start held high in the DONE cycle with a new d -> next ready exactly 24 edges later, no idle cycle.
- Reset abort: clrn low at edge 10 -> all outputs zero immediately, no ready pulse; a fresh start after release completes normally.
